masked_sram_rw_init: RTL and testbench

MASKED_SRAM_RW_INIT -- requirements
Module: masked_sram_rw_init

---
 rtl/masked_sram_rw_init.sv | 150 +++++++++++++++
 tb/tb_masked_sram_rw_init.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/masked_sram_rw_init.sv
// masked_sram_rw_init: single-port SRAM with per-segment write mask.
// After reset, a zeroing sweep runs over every address, and then the array
// accepts accesses. Read data is registered and held until the next read.
// Compile option MASKED_SRAM_OUTREG_EN adds an output register stage, which
// gives a read latency of 2 instead of 1.
module masked_sram_rw_init #(
  parameter int DEPTH     = 256,
  parameter int WIDTH     = 24,
  parameter int MASK_GRAN = 6
) (
  input  logic                             RW0_clk,
  input  logic                             RW0_reset,
  input  logic [$clog2(DEPTH)-1:0]         RW0_addr,
  input  logic                             RW0_en,
  input  logic                             RW0_wmode,
  input  logic [WIDTH/MASK_GRAN-1:0]       RW0_wmask,
  input  logic [WIDTH-1:0]                 RW0_wdata,
  output logic [WIDTH-1:0]                 RW0_rdata,
  output logic                             RW0_rvalid,
  output logic                             RW0_ready
);

  localparam int ADDR_W   = $clog2(DEPTH);
  localparam int MASK_SEG = WIDTH / MASK_GRAN;

  // A word must split into whole mask segments, and the init counter must cover the array exactly
  generate
    if ((WIDTH % MASK_GRAN) != 0) begin : g_badGran
      $error("masked_sram_rw_init: WIDTH must be a multiple of MASK_GRAN");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_badDepth
      $error("masked_sram_rw_init: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  logic [ADDR_W-1:0]     r_initCnt;
  logic                  r_ready;
  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [WIDTH-1:0]      r_rdata;
  logic                  r_rvalid;

  logic                  w_memWe;
  logic [ADDR_W-1:0]     w_memAddr;
  logic [MASK_SEG-1:0]   w_memMask;
  logic [WIDTH-1:0]      w_memData;
  logic                  w_rdReq;

  // Pick the array write port source: the zeroing sweep owns it in INIT, the user owns it in RUN
  always_comb begin
    w_memWe   = 1'b0;
    w_memAddr = RW0_addr;
    w_memMask = RW0_wmask;
    w_memData = RW0_wdata;
    w_rdReq   = 1'b0;
    if (r_state == ST_INIT) begin
      w_memWe   = 1'b1;
      w_memAddr = r_initCnt;
      w_memMask = '1;
      w_memData = '0;
    end else begin
      w_memWe = RW0_en & RW0_wmode;
      w_rdReq = RW0_en & ~RW0_wmode;
    end
  end

  // Control FSM: sweep addresses in INIT and raise ready in the cycle after the last one is written
  always_ff @(posedge RW0_clk or posedge RW0_reset) begin
    if (RW0_reset) begin
      r_state   <= ST_INIT;
      r_initCnt <= '0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_initCnt == ADDR_W'(DEPTH - 1)) begin
            r_state   <= ST_RUN;
            r_ready   <= 1'b1;
            r_initCnt <= '0;
          end else begin
            r_initCnt <= r_initCnt + 1'b1;
          end
        end
        ST_RUN: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_INIT;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: only segments with their mask bit set are updated; contents are never reset
  always_ff @(posedge RW0_clk) begin
    if (w_memWe) begin
      for (int s = 0; s < MASK_SEG; s++) begin
        if (w_memMask[s]) begin
          r_mem[w_memAddr][s*MASK_GRAN +: MASK_GRAN] <= w_memData[s*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
  end

  // Read stage: capture the addressed word on a read request and hold it until the next read
  always_ff @(posedge RW0_clk or posedge RW0_reset) begin
    if (RW0_reset) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rdReq;
      if (w_rdReq) begin
        r_rdata <= r_mem[RW0_addr];
      end
    end
  end

`ifdef MASKED_SRAM_OUTREG_EN
  logic [WIDTH-1:0] r_rdataOut;
  logic             r_rvalidOut;

  // Extra output stage: delays data and valid by one cycle while keeping the hold-until-next-read behaviour
  always_ff @(posedge RW0_clk or posedge RW0_reset) begin
    if (RW0_reset) begin
      r_rdataOut  <= '0;
      r_rvalidOut <= 1'b0;
    end else begin
      r_rvalidOut <= r_rvalid;
      if (r_rvalid) begin
        r_rdataOut <= r_rdata;
      end
    end
  end

  assign RW0_rdata  = r_rdataOut;
  assign RW0_rvalid = r_rvalidOut;
`else
  assign RW0_rdata  = r_rdata;
  assign RW0_rvalid = r_rvalid;
`endif

  assign RW0_ready = r_ready;

endmodule

// File: tb/tb_masked_sram_rw_init.sv
// tb_masked_sram_rw_init: directed bench for masked_sram_rw_init with default
// geometry. Reads are scored against a shadow model through a queue; the
// expected latency follows MASKED_SRAM_OUTREG_EN.
module tb_masked_sram_rw_init;

  localparam int DEPTH     = 256;
  localparam int WIDTH     = 24;
  localparam int MASK_GRAN = 6;
  localparam int ADDR_W    = $clog2(DEPTH);
  localparam int MSEG      = WIDTH / MASK_GRAN;
`ifdef MASKED_SRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              RW0_clk;
  logic              RW0_reset;
  logic [ADDR_W-1:0] RW0_addr;
  logic              RW0_en;
  logic              RW0_wmode;
  logic [MSEG-1:0]   RW0_wmask;
  logic [WIDTH-1:0]  RW0_wdata;
  logic [WIDTH-1:0]  RW0_rdata;
  logic              RW0_rvalid;
  logic              RW0_ready;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               cyc;
  } exp_t;

  exp_t             sbQ[$];
  logic [WIDTH-1:0] model [DEPTH];
  int               total = 0;
  int               bad = 0;
  int               cycleCnt = 0;
  bit               tbRun = 0;

  masked_sram_rw_init #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_GRAN(MASK_GRAN)
  ) dut (
    .RW0_clk(RW0_clk), .RW0_reset(RW0_reset), .RW0_addr(RW0_addr),
    .RW0_en(RW0_en), .RW0_wmode(RW0_wmode), .RW0_wmask(RW0_wmask),
    .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata), .RW0_rvalid(RW0_rvalid),
    .RW0_ready(RW0_ready)
  );

  // Free-running clock, 10 ns period
  initial begin
    RW0_clk = 1'b0;
    forever #5 RW0_clk = ~RW0_clk;
  end

  // Edge counter used to time read latency
  always @(posedge RW0_clk) cycleCnt++;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one request for one clock; the model and scoreboard follow accepted requests only
  task automatic applyStimulus(input bit en, input bit wmode, input logic [ADDR_W-1:0] addr,
                               input logic [MSEG-1:0] mask, input logic [WIDTH-1:0] data);
    exp_t e;
    RW0_en    = en;
    RW0_wmode = wmode;
    RW0_addr  = addr;
    RW0_wmask = mask;
    RW0_wdata = data;
    if (en && tbRun) begin
      if (wmode) begin
        for (int s = 0; s < MSEG; s++)
          if (mask[s]) model[addr][s*MASK_GRAN +: MASK_GRAN] = data[s*MASK_GRAN +: MASK_GRAN];
      end else begin
        e.data = model[addr];
        e.cyc  = cycleCnt + LAT;
        sbQ.push_back(e);
      end
    end
    @(posedge RW0_clk);
    #1;
    RW0_en = 1'b0;
  endtask

  // Clear the model and count INIT cycles while hammering the array with requests that must be ignored
  task automatic runInit(input string tag);
    int cnt;
    cnt = 0;
    tbRun = 0;
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
    while (!RW0_ready && cnt < 2 * DEPTH) begin
      RW0_en    = 1'b1;
      RW0_wmode = ~cnt[0];
      RW0_addr  = ADDR_W'(5);
      RW0_wmask = '1;
      RW0_wdata = 24'hFFFFFF;
      @(posedge RW0_clk);
      #1;
      cnt++;
    end
    RW0_en = 1'b0;
    checkOutput(tag, cnt, DEPTH);
    tbRun = 1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, '0, '0, '0);
  endtask

  // Scoreboard: every rvalid pulse must match the oldest outstanding read, on time
  always @(negedge RW0_clk) begin
    exp_t e;
    if (RW0_rvalid) begin
      if (sbQ.size() == 0) begin
        checkOutput("rvalid_without_read", RW0_rvalid, 1'b0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("rdata", RW0_rdata, e.data);
        checkOutput("read_latency", cycleCnt, e.cyc);
      end
    end
  end

  // Watchdog so the run can never hang
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    RW0_reset = 1'b1;
    RW0_en    = 1'b0;
    RW0_wmode = 1'b0;
    RW0_addr  = '0;
    RW0_wmask = '0;
    RW0_wdata = '0;
    repeat (3) @(posedge RW0_clk);
    #1;
    checkOutput("reset_ready", RW0_ready, 1'b0);
    checkOutput("reset_rvalid", RW0_rvalid, 1'b0);
    checkOutput("reset_rdata", RW0_rdata, '0);
    RW0_reset = 1'b0;

    // Power-up sweep with ignored write/read requests to address 5
    runInit("init_cycles_first");
    checkOutput("rdata_after_init", RW0_rdata, '0);

    // Every address reads back zero, including address 5
    for (int a = 0; a < DEPTH; a++) applyStimulus(1'b1, 1'b0, ADDR_W'(a), '0, '0);
    idle(3);

    // Masked overwrite of address 0x10
    applyStimulus(1'b1, 1'b1, 8'h10, 4'b1111, 24'hABCDEF);
    applyStimulus(1'b1, 1'b1, 8'h10, 4'b0101, 24'h123456);
    applyStimulus(1'b1, 1'b0, 8'h10, '0, '0);
    idle(3);

    // Zero mask leaves the word untouched
    applyStimulus(1'b1, 1'b1, 8'h10, 4'b0000, 24'h000000);
    applyStimulus(1'b1, 1'b0, 8'h10, '0, '0);
    idle(3);

    // Read data holds across writes and idle cycles
    applyStimulus(1'b1, 1'b1, 8'h03, 4'b1111, 24'h000777);
    applyStimulus(1'b1, 1'b0, 8'h03, '0, '0);
    applyStimulus(1'b1, 1'b1, 8'h03, 4'b1111, 24'h5A5A5A);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, '0, '0, '0);
      checkOutput("rdata_hold", RW0_rdata, 24'h000777);
    end
    applyStimulus(1'b1, 1'b0, 8'h03, '0, '0);
    applyStimulus(1'b1, 1'b1, 8'h03, 4'b0110, 24'hC3C3C3);
    applyStimulus(1'b1, 1'b0, 8'h03, '0, '0);
    idle(3);

    // Mixed random traffic over a small address window
    for (int i = 0; i < 40; i++)
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)),
                    MSEG'($urandom), WIDTH'($urandom));
    idle(4);
    checkOutput("scoreboard_drained_run", sbQ.size(), 0);

    // Reset in RUN drops everything at once and restarts the sweep
    RW0_reset = 1'b1;
    #1;
    checkOutput("run_reset_ready", RW0_ready, 1'b0);
    checkOutput("run_reset_rvalid", RW0_rvalid, 1'b0);
    checkOutput("run_reset_rdata", RW0_rdata, '0);
    @(posedge RW0_clk);
    #1;
    RW0_reset = 1'b0;
    runInit("init_cycles_after_run_reset");
    applyStimulus(1'b1, 1'b0, 8'h10, '0, '0);
    applyStimulus(1'b1, 1'b0, 8'h03, '0, '0);
    idle(3);

    // Reset at INIT cycle 100, held for 2 cycles
    applyStimulus(1'b1, 1'b1, 8'h07, 4'b1111, 24'h777777);
    RW0_reset = 1'b1;
    @(posedge RW0_clk);
    #1;
    RW0_reset = 1'b0;
    tbRun = 0;
    repeat (100) @(posedge RW0_clk);
    #1;
    checkOutput("mid_init_ready", RW0_ready, 1'b0);
    RW0_reset = 1'b1;
    repeat (2) @(posedge RW0_clk);
    #1;
    RW0_reset = 1'b0;
    runInit("init_cycles_after_init_reset");
    applyStimulus(1'b1, 1'b0, 8'h07, '0, '0);
    applyStimulus(1'b1, 1'b0, 8'h05, '0, '0);
    idle(4);
    checkOutput("scoreboard_drained_end", sbQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
